// File: rtl/booth_acc_pkg.sv
// Shared definitions for the radix-4 Booth multiplier:
// FSM encoding, Booth triplet codes and default operand width.
package booth_acc_pkg;

  localparam int BA_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [2:0] BT_Z0  = 3'b000;
  localparam logic [2:0] BT_P1A = 3'b001;
  localparam logic [2:0] BT_P1B = 3'b010;
  localparam logic [2:0] BT_P2  = 3'b011;
  localparam logic [2:0] BT_M2  = 3'b100;
  localparam logic [2:0] BT_M1A = 3'b101;
  localparam logic [2:0] BT_M1B = 3'b110;
  localparam logic [2:0] BT_Z1  = 3'b111;

endpackage

// File: rtl/booth_acc.sv
// Radix-4 Booth datapath: accumulator, multiplier shift
// register and iteration FSM; emits triplets to the controller.
module booth_acc
  import booth_acc_pkg::*;
#(
  parameter int W = BA_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   multiplicator,
  input  logic [W:0]     multiplicand_pp,
  input  logic           op,
  output logic [2:0]     booth,
  output logic           ctrl_en,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int ITER = W / 2;
  localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);

  state_t          state_q;
  logic [W+1:0]    acc_q;
  logic [W-1:0]    q_q;
  logic            qm1_q;
  logic [CW-1:0]   cnt_q;
  logic [2*W-1:0]  prod_q;
  logic            done_q;
  logic            ctrl_en_q;
  logic            busy_q;

  logic [W+1:0]    pp_x;
  logic [W+1:0]    s_d;
  logic [W+1:0]    acc_d;
  logic [W-1:0]    q_d;

  // Add or subtract the selected partial product, then shift right by two
  always_comb begin
    pp_x  = {multiplicand_pp[W], multiplicand_pp};
    s_d   = op ? (acc_q + ~pp_x + (W+2)'(1))
               : (acc_q + pp_x);
    acc_d = {s_d[W+1], s_d[W+1], s_d[W+1:2]};
    q_d   = {s_d[1:0], q_q[W-1:2]};
  end

  // Iteration FSM with datapath registers and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      q_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      prod_q    <= '0;
      done_q    <= 1'b0;
      ctrl_en_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q     <= '0;
            q_q       <= multiplicator;
            qm1_q     <= 1'b0;
            cnt_q     <= '0;
            state_q   <= ST_RUN;
            ctrl_en_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          qm1_q <= q_q[1];
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_q   <= ST_DONE;
            ctrl_en_q <= 1'b0;
            done_q    <= 1'b1;
            prod_q    <= {acc_d[W-1:0], q_d};
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= ST_IDLE;
          done_q    <= 1'b0;
          ctrl_en_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign booth   = {q_q[1], q_q[0], qm1_q};
  assign ctrl_en = ctrl_en_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = prod_q;

endmodule

// File: tb/tb_booth_acc.sv
// Bench for booth_acc: behavioural Booth decode as controller,
// scoreboard of exact signed products checked on done.
module tb_booth_acc;

  localparam int W    = 16;
  localparam int ITER = W / 2;

  logic           clk;
  logic           rst;
  logic           start;
  logic [W-1:0]   multiplicator;
  logic [W:0]     multiplicand_pp;
  logic           op;
  logic [2:0]     booth;
  logic           ctrl_en;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  logic [W-1:0]   x_cur;

  logic [2*W-1:0] exp_q[$];
  int n_vec;
  int n_err;
  int en_cnt;

  booth_acc #(.W(W)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .multiplicator   (multiplicator),
    .multiplicand_pp (multiplicand_pp),
    .op              (op),
    .booth           (booth),
    .ctrl_en         (ctrl_en),
    .busy            (busy),
    .done            (done),
    .product         (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Controller model: Booth triplet -> partial product and add/sub
  always_comb begin
    multiplicand_pp = '0;
    op              = 1'b0;
    case (booth)
      3'b001, 3'b010: multiplicand_pp = {x_cur[W-1], x_cur};
      3'b011:         multiplicand_pp = {x_cur, 1'b0};
      3'b100: begin
        multiplicand_pp = {x_cur, 1'b0};
        op = 1'b1;
      end
      3'b101, 3'b110: begin
        multiplicand_pp = {x_cur[W-1], x_cur};
        op = 1'b1;
      end
      default: ;
    endcase
  end

  task automatic check(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: pop the scoreboard on every done pulse
  always @(negedge clk) begin
    if (rst) begin
      en_cnt = 0;
    end else begin
      if (ctrl_en) en_cnt++;
      if (done) begin
        check("ctrl_en_cycles", 64'(en_cnt), 64'(ITER));
        check("busy_at_done", 64'(busy), 64'd1);
        check("ctrl_en_at_done", 64'(ctrl_en), 64'd0);
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          check("product", 64'(product), 64'(exp_q.pop_front()));
        end
        en_cnt = 0;
      end
    end
  end

  // mode 0: plain, 1: extra start mid-run, 2: reset mid-run
  task automatic run(input logic [W-1:0] a,
                     input logic [W-1:0] b,
                     input int mode);
    int lat;
    bit seen;
    int pa;
    int pb;
    logic [2*W-1:0] e;
    logic [W:0] ax;
    logic [2:0] trip;
    pa = int'($signed(a));
    pb = int'($signed(b));
    e  = (2*W)'(pa * pb);
    ax = {a, 1'b0};
    @(posedge clk);
    #1;
    start = 1'b1;
    multiplicator = a;
    x_cur = b;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    start = 1'b0;
    multiplicator = W'($urandom);
    check("busy_after_start", 64'(busy), 64'd1);
    check("ctrl_en_after_start", 64'(ctrl_en), 64'd1);
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (mode == 1 && lat == 3) begin
        start = 1'b1;
        multiplicator = ~a;
      end
      if (mode == 1 && lat == 4) start = 1'b0;
      if (mode == 2 && lat == 4) begin
        rst = 1'b1;
        #1;
        check("rst_product", 64'(product), 64'd0);
        check("rst_booth", 64'(booth), 64'd0);
        check("rst_ctrl_en", 64'(ctrl_en), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (lat <= ITER) begin
        trip = ax[2*lat -: 3];
        check("booth_triplet", 64'(booth), 64'(trip));
        check("busy_in_run", 64'(busy), 64'd1);
      end
      if (done) seen = 1'b1;
    end
    if (!seen) begin
      check("done_timeout", 64'd1, 64'd0);
      exp_q.delete();
    end else begin
      check("latency", 64'(lat), 64'(ITER + 1));
      @(negedge clk);
      check("busy_after_done", 64'(busy), 64'd0);
      check("done_one_cycle", 64'(done), 64'd0);
      check("product_held", 64'(product), 64'(e));
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    en_cnt = 0;
    rst = 1'b1;
    start = 1'b0;
    multiplicator = '0;
    x_cur = '0;
    #1;
    check("reset_product", 64'(product), 64'd0);
    check("reset_booth", 64'(booth), 64'd0);
    check("reset_ctrl_en", 64'(ctrl_en), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    run(16'd5, 16'd3, 0);
    check("p5x3", 64'(product), 64'h0000_000F);
    run(16'd6, -16'sd7, 0);
    check("p6xm7", 64'(product), 64'hFFFF_FFD6);
    run(16'h8000, 16'h8000, 0);
    check("pmin_sq", 64'(product), 64'h4000_0000);
    run(16'h8000, 16'h7FFF, 0);
    check("pmin_max", 64'(product), 64'hC000_8000);
    run(16'd0, 16'h1234, 0);
    check("pzero", 64'(product), 64'd0);
    run(16'd1234, -16'sd77, 1);
    run(16'd100, 16'd200, 2);
    run(16'd12, -16'sd12, 0);
    check("p12xm12", 64'(product), 64'hFFFF_FF70);
    for (int i = 0; i < 30; i++) begin
      run(W'($urandom), W'($urandom), 0);
    end
    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/booth_acc.md
Name: booth_acc

Overview:
- Datapath end of the radix-4 Booth multiplier. Consumes the partial-product select (multiplicand_pp, op) from the Booth controller and produces the next Booth triplet for it.
- Holds the accumulator and multiplier shift register, iterates W/2 times, and delivers a 2W-bit signed product with a done pulse.
- Sits beside the controller inside the multiplier top. The controller decodes `booth` combinationally into op/multiplicand_pp within the same cycle.

Parameters:
- W, 16, operand width in bits (signed two's complement); must be even, minimum 4.
- ITER, W/2, number of radix-4 iterations (derived; not to be overridden).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a multiply; sampled only in IDLE
- multiplicator  in  W  signed multiplier; captured on accepted start
- multiplicand_pp  in  W+1  signed partial product from controller (0, ±x sign-extended, or 2x)
- op  in  1  0 = add multiplicand_pp to accumulator, 1 = subtract it
- booth  out  3  current triplet {q[1], q[0], q_m1} for the controller
- ctrl_en  out  1  high during RUN; enables the controller
- busy  out  1  high in RUN and DONE
- done  out  1  one-cycle pulse: product valid
- product  out  2W  signed result; held until the next accepted start

Behaviour:
- Reset values (async on rst=1): state=IDLE, acc=0, q=0, q_m1=0, cnt=0, product=0, done=0; booth=000, ctrl_en=0, busy=0.
- Registers:
  - acc: W+2 bits, signed.
  - q: W bits.
  - q_m1: 1 bit.
  - cnt: enough bits for ITER-1.
- booth is driven only from registers (q[1:0], q_m1). There is no combinational path from inputs to booth, so there is no loop with the controller.
- FSM IDLE -> RUN -> DONE -> IDLE:
  - IDLE, start=1: acc<=0, q<=multiplicator, q_m1<=0, cnt<=0 -> RUN. With start=0 all registers hold.
  - RUN, every cycle:
    - s = acc + (op ? -sext(multiplicand_pp) : sext(multiplicand_pp)), computed in W+2 bits; subtraction is acc + ~pp + 1.
    - Arithmetic right-shift {s, q, q_m1} by 2: acc<={s[W+1],s[W+1],s[W+1:2]}, q<={s[1:0],q[W-1:2]}, q_m1<=q[1].
    - cnt<=cnt+1.
    - When cnt==ITER-1 -> DONE.
  - DONE: product<={acc[W-1:0], q}; done=1 this cycle only -> IDLE.
- Latency: start sampled at edge 0; RUN occupies ITER cycles; done is high in cycle ITER+1 (9 cycles after start for W=16). Throughput is one multiply per ITER+2 cycles.
- ctrl_en=1 exactly in RUN cycles. busy=1 in RUN and DONE.
- start during RUN or DONE is ignored and not queued.
- Overflow: none possible. W+2-bit acc covers |2x| plus sign growth. Product range is −2^(2W−2)..2^(2W−2) and fits in 2W bits.
- Reset mid-operation: immediate return to reset values; the partial result is discarded and product reads 0.
- Inputs multiplicand_pp/op are don't-care outside RUN.

Decomposition:
- Shared package holds:
  - FSM state encoding: IDLE=2'b00, RUN=2'b01, DONE=2'b10.
  - Booth triplet constants 000..111, shared with the controller.
  - Default W.
- No sub-module; the add/sub and shift are a single always block with a combinational sum.
- The bench instantiates booth_acc with the existing controller (or a behavioural model of its decode) under a thin top.

Test Plan:
- W=16; start with multiplicator=5, multiplicand=3 -> done in cycle 9, product=0x0000000F, ctrl_en high for exactly 8 cycles.
- multiplicator=6, multiplicand=-7 -> product=0xFFFFFFD6 (-42); booth sequence on first RUN cycle = 3'b100.
- multiplicator=-32768, multiplicand=-32768 -> product=0x40000000; multiplicator=-32768, multiplicand=32767 -> product=0xC0008000.
- multiplicator=0, multiplicand=0x1234 -> product=0; booth=000 in every RUN cycle.
- start pulsed again in RUN cycle 3 with different operands -> ignored; first result correct; busy stays high until after done.
- rst asserted in RUN cycle 4 -> outputs at reset values immediately. A new start afterwards (12×-12) -> product=0xFFFFFF70.
